ram_port_arbiter: RTL and testbench

// - Shares the single-port 256x16 program/data RAM between two requesters:
//   the switch/button programming logic (P) and the LED CPU (C).
// - Sits between both masters and the RAM. It registers the winning

---
 rtl/ram_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// ram_port_arbiter : round-robin arbiter sharing one 256x16 RAM port between
//                    the programming logic (P) and the LED CPU (C).
// Optional: ARB_STATS_EN adds per-requester grant counters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ram_port_arbiter #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog_lock,
   input  logic          prog_req,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW-1:0] prog_wdata,
   output logic          prog_gnt,
   output logic          prog_rvalid,
   output logic [DW-1:0] prog_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_halt,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]   prog_cnt,
   output logic [15:0]   cpu_cnt
`endif
);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_GRANT_P = 2'd1;
   localparam logic [1:0] c_GRANT_C = 2'd2;
   localparam logic [1:0] c_LOCK    = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_next_state;
   logic          r_last_win_p;
   logic          w_p_elig;
   logic          w_c_elig;
   logic          w_win_p;
   logic          w_win_c;

   logic          w_ram_en;
   logic          w_ram_we;
   logic [AW-1:0] w_ram_addr;
   logic [DW-1:0] w_ram_wdata;

   logic          r_ram_en;
   logic          r_ram_we;
   logic [AW-1:0] r_ram_addr;
   logic [DW-1:0] r_ram_wdata;
   logic          r_prog_gnt;
   logic          r_cpu_gnt;
   logic          r_prog_iss_rd;
   logic          r_cpu_iss_rd;
   logic          r_prog_rvalid;
   logic          r_cpu_rvalid;

   // A requester granted last cycle sits out one arbitration round. The CPU
   // is blocked both by the live lock input and by the registered LOCK state,
   // so it resumes one cycle after the lock drops.
   assign w_p_elig = prog_req && !r_prog_gnt;
   assign w_c_elig = cpu_req && !r_cpu_gnt && !prog_lock && (r_state != c_LOCK);
   assign w_win_p  = w_p_elig && (!w_c_elig || !r_last_win_p);
   assign w_win_c  = w_c_elig && !w_win_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = c_IDLE;
      if (prog_lock) begin
         w_next_state = c_LOCK;
      end else if (w_win_p) begin
         w_next_state = c_GRANT_P;
      end else if (w_win_c) begin
         w_next_state = c_GRANT_C;
      end
   end

   always_comb begin
      w_ram_en    = w_win_p || w_win_c;
      w_ram_we    = 1'b0;
      w_ram_addr  = r_ram_addr;
      w_ram_wdata = r_ram_wdata;
      if (w_win_p) begin
         w_ram_we    = prog_we;
         w_ram_addr  = prog_addr;
         w_ram_wdata = prog_wdata;
      end else if (w_win_c) begin
         w_ram_we    = cpu_we;
         w_ram_addr  = cpu_addr;
         w_ram_wdata = cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ram_en      <= 1'b0;
         r_ram_we      <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_wdata   <= '0;
         r_prog_gnt    <= 1'b0;
         r_cpu_gnt     <= 1'b0;
         r_prog_iss_rd <= 1'b0;
         r_cpu_iss_rd  <= 1'b0;
         r_prog_rvalid <= 1'b0;
         r_cpu_rvalid  <= 1'b0;
         r_last_win_p  <= 1'b0;
      end else begin
         r_ram_en      <= w_ram_en;
         r_ram_we      <= w_ram_we;
         r_ram_addr    <= w_ram_addr;
         r_ram_wdata   <= w_ram_wdata;
         r_prog_gnt    <= w_win_p;
         r_cpu_gnt     <= w_win_c;
         r_prog_iss_rd <= w_win_p && !prog_we;
         r_cpu_iss_rd  <= w_win_c && !cpu_we;
         r_prog_rvalid <= r_prog_iss_rd;
         r_cpu_rvalid  <= r_cpu_iss_rd;
         if (w_ram_en) begin
            r_last_win_p <= w_win_p;
         end
      end
   end

   assign ram_en      = r_ram_en;
   assign ram_we      = r_ram_we;
   assign ram_addr    = r_ram_addr;
   assign ram_wdata   = r_ram_wdata;
   assign prog_gnt    = r_prog_gnt;
   assign cpu_gnt     = r_cpu_gnt;
   assign prog_rvalid = r_prog_rvalid;
   assign cpu_rvalid  = r_cpu_rvalid;
   assign prog_rdata  = r_prog_rvalid ? ram_rdata : '0;
   assign cpu_rdata   = r_cpu_rvalid  ? ram_rdata : '0;
   assign cpu_halt    = (r_state == c_LOCK);

`ifdef ARB_STATS_EN
   logic [15:0] r_prog_cnt;
   logic [15:0] r_cpu_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prog_cnt <= '0;
         r_cpu_cnt  <= '0;
      end else begin
         if (w_win_p) r_prog_cnt <= r_prog_cnt + 16'd1;
         if (w_win_c) r_cpu_cnt  <= r_cpu_cnt + 16'd1;
      end
   end

   assign prog_cnt = r_prog_cnt;
   assign cpu_cnt  = r_cpu_cnt;
`else
   // Grant statistics are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_ram_port_arbiter : directed scoreboard bench for ram_port_arbiter with a
//                       behavioural 256x16 RAM. Honours ARB_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        prog_lock, prog_req, prog_we;
   logic [7:0]  prog_addr;
   logic [15:0] prog_wdata;
   logic        prog_gnt, prog_rvalid;
   logic [15:0] prog_rdata;
   logic        cpu_req, cpu_we;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt, cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        cpu_halt;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
`ifdef ARB_STATS_EN
   logic [15:0] prog_cnt, cpu_cnt;
`endif

   ram_port_arbiter #(.AW(8), .DW(16)) dut (
      .clk(clk), .rst(rst), .prog_lock(prog_lock),
      .prog_req(prog_req), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .prog_gnt(prog_gnt), .prog_rvalid(prog_rvalid),
      .prog_rdata(prog_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
      , .prog_cnt(prog_cnt), .cpu_cnt(cpu_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural RAM: read data appears the cycle after a read enable.
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int          n_chk = 0;
   int          n_err = 0;
   logic [15:0] p_q[$];
   logic [15:0] c_q[$];
   logic [15:0] p_exp, c_exp;
   int          c_gnt_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expected read.
   always @(negedge clk) begin
      if (cpu_gnt) c_gnt_cnt++;
      if (prog_rvalid) begin
         if (p_q.size() == 0) chk("p_rvalid_unexpected", 1, 0);
         else begin
            p_exp = p_q.pop_front();
            chk("p_rdata", {16'h0, prog_rdata}, {16'h0, p_exp});
         end
      end
      if (cpu_rvalid) begin
         if (c_q.size() == 0) chk("c_rvalid_unexpected", 1, 0);
         else begin
            c_exp = c_q.pop_front();
            chk("c_rdata", {16'h0, cpu_rdata}, {16'h0, c_exp});
         end
      end
   end

   task automatic p_access(input logic we, input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] exp_rd);
      bit got = 0;
      prog_req = 1'b1; prog_we = we; prog_addr = a; prog_wdata = d;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (prog_gnt) begin got = 1; break; end
      end
      chk("p_gnt_seen", {31'h0, got}, 1);
      if (got) begin
         chk("p_ram_en",   {31'h0, ram_en}, 1);
         chk("p_ram_we",   {31'h0, ram_we}, {31'h0, we});
         chk("p_ram_addr", {24'h0, ram_addr}, {24'h0, a});
         if (we) chk("p_ram_wdata", {16'h0, ram_wdata}, {16'h0, d});
         else    p_q.push_back(exp_rd);
      end
      prog_req = 1'b0;
   endtask

   task automatic c_access(input logic we, input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] exp_rd);
      bit got = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_gnt) begin got = 1; break; end
      end
      chk("c_gnt_seen", {31'h0, got}, 1);
      if (got) begin
         chk("c_ram_we",   {31'h0, ram_we}, {31'h0, we});
         chk("c_ram_addr", {24'h0, ram_addr}, {24'h0, a});
         if (we) chk("c_ram_wdata", {16'h0, ram_wdata}, {16'h0, d});
         else    c_q.push_back(exp_rd);
      end
      cpu_req = 1'b0;
   endtask

   task automatic chk_zero();
      chk("rst_ram_en",    {31'h0, ram_en}, 0);
      chk("rst_ram_we",    {31'h0, ram_we}, 0);
      chk("rst_ram_addr",  {24'h0, ram_addr}, 0);
      chk("rst_ram_wdata", {16'h0, ram_wdata}, 0);
      chk("rst_gnts",      {30'h0, prog_gnt, cpu_gnt}, 0);
      chk("rst_rvalids",   {30'h0, prog_rvalid, cpu_rvalid}, 0);
      chk("rst_rdata",     {prog_rdata, cpu_rdata}, 0);
      chk("rst_cpu_halt",  {31'h0, cpu_halt}, 0);
`ifdef ARB_STATS_EN
      chk("rst_stats",     {prog_cnt, cpu_cnt}, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int c0;
      bit got;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      ram_rdata = 16'h0;
      rst = 1'b1; prog_lock = 1'b0;
      prog_req = 1'b0; prog_we = 1'b0; prog_addr = 8'h0; prog_wdata = 16'h0;
      cpu_req = 1'b0;  cpu_we = 1'b0;  cpu_addr = 8'h0;  cpu_wdata = 16'h0;

      // Reset values, with a P write request held through reset
      prog_req = 1'b1; prog_we = 1'b1; prog_addr = 8'h10; prog_wdata = 16'h1111;
      repeat (3) tick();
      chk_zero();
      rst = 1'b0;
      lat = 0; got = 0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (prog_gnt) begin lat = i; got = 1; break; end
      end
      prog_req = 1'b0;
      chk("first_gnt_after_rst", {31'h0, got && lat >= 1 && lat <= 2}, 1);
      tick();

      // P write 0x05 <= A1B2, then C reads it back
      p_access(1'b1, 8'h05, 16'hA1B2, 16'h0);
      chk("p_wr_no_cpu_gnt", {31'h0, cpu_gnt}, 0);
      tick();
      c_access(1'b0, 8'h05, 16'h0, 16'hA1B2);
      tick();
      chk("c_rvalid_at_n2", {31'h0, cpu_rvalid}, 1);
      tick();

      // Simultaneous same-address P write and C read: P wins, C sees new data
      fork
         p_access(1'b1, 8'h20, 16'h5A5A, 16'h0);
         c_access(1'b0, 8'h20, 16'h0, 16'h5A5A);
      join
      repeat (2) tick();
      p_access(1'b0, 8'h10, 16'h0, 16'h1111);
      repeat (2) tick();

      // C read in flight when lock rises still completes; C write then stalls
      c_access(1'b0, 8'h05, 16'h0, 16'hA1B2);
      prog_lock = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'hC0DE;
      tick();
      chk("lock_halt", {31'h0, cpu_halt}, 1);
      chk("lock_no_cpu_gnt", {31'h0, cpu_gnt}, 0);
      c0 = c_gnt_cnt;
      for (int i = 0; i < 4; i++) p_access(1'b1, 8'(i), 16'h1000 + 16'(i), 16'h0);
      tick();
      chk("lock_cpu_gnt_count", c_gnt_cnt - c0, 0);
      chk("lock_halt_held", {31'h0, cpu_halt}, 1);
      prog_lock = 1'b0;
      lat = 0; got = 0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (cpu_gnt) begin lat = i; got = 1; break; end
      end
      chk("unlock_gnt_latency", lat, 2);
      if (got) chk("unlock_c_addr", {24'h0, ram_addr}, 32'h40);
      cpu_req = 1'b0;
      chk("unlock_halt", {31'h0, cpu_halt}, 0);
      tick();
      p_access(1'b0, 8'h02, 16'h0, 16'h1002);
      tick();
      c_access(1'b0, 8'h40, 16'h0, 16'hC0DE);
      repeat (3) tick();

      // C read in flight when reset hits: no rvalid must appear
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_gnt) begin got = 1; break; end
      end
      chk("rst_inflight_gnt", {31'h0, got}, 1);
      cpu_req = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst_inflight_no_rvalid", {31'h0, cpu_rvalid}, 0);
      // Both requesters held through reset: strict P,C alternation
      prog_req = 1'b1; prog_we = 1'b1; prog_addr = 8'h30; prog_wdata = 16'h3333;
      cpu_req  = 1'b1; cpu_we  = 1'b1; cpu_addr  = 8'h31; cpu_wdata  = 16'h4444;
      tick();
      chk_zero();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("alt_gnt", {30'h0, prog_gnt, cpu_gnt}, (i % 2 == 0) ? 32'h2 : 32'h1);
      end
      prog_req = 1'b0; cpu_req = 1'b0;
      tick();
`ifdef ARB_STATS_EN
      chk("stats_counts", {prog_cnt, cpu_cnt}, 32'h0003_0003);
`endif
      repeat (4) tick();
      chk("p_queue_drained", p_q.size(), 0);
      chk("c_queue_drained", c_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
